csr_regfile: RTL and testbench

Machine-mode control and status register file for the RV32I core. It is the storage end of the CSR path: it supplies the old CSR value that feeds the CSR ALU, and it commits the ALU result on the next clock edge. It also maintains the 64-bit cycle and retired-instruction counters, and it performs the trap-entry and `mret` updates of `mstatus`, `mepc` and `mcause`.

---
 rtl/csr_regfile.sv | 135 +++++++++++++
 tb/tb_csr_regfile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage for the RV32I core: combinational read port, ALU write-back,
// 64-bit cycle/instret counters, and trap-entry / mret updates of mstatus, mepc, mcause.
module csr_regfile #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_rd_illegal,
  input  logic        csr_we,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  output logic        csr_wr_illegal,
  input  logic        inst_retire,
  input  logic        trap_en,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_en,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] LOW2_MASK = 32'hFFFF_FFFC;

  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause;
  logic [63:0] mcycle, minstret;
  logic [63:0] mcycle_nxt, minstret_nxt;
  logic [31:0] mstatus;
  logic        writable, wr_ok;

  assign mstatus = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};

  always_comb begin
    writable = 1'b0;
    case (csr_waddr)
      A_MSTATUS, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: writable = 1'b1;
      default: writable = 1'b0;
    endcase
  end

  assign csr_wr_illegal = csr_we & ~writable;
  // A trap in the same cycle swallows the CSR instruction's write entirely.
  assign wr_ok = csr_we & writable & ~trap_en;

  always_comb begin
    csr_rdata      = 32'h0;
    csr_rd_illegal = 1'b0;
    case (csr_raddr)
      A_MSTATUS:               csr_rdata = mstatus;
      A_MTVEC:                 csr_rdata = mtvec;
      A_MSCRATCH:              csr_rdata = mscratch;
      A_MEPC:                  csr_rdata = mepc;
      A_MCAUSE:                csr_rdata = mcause;
      A_MCYCLE, A_CYCLE:       csr_rdata = mcycle[31:0];
      A_MCYCLEH, A_CYCLEH:     csr_rdata = mcycle[63:32];
      A_MINSTRET, A_INSTRET:   csr_rdata = minstret[31:0];
      A_MINSTRETH, A_INSTRETH: csr_rdata = minstret[63:32];
      A_MHARTID:               csr_rdata = HART_ID;
      default:                 csr_rd_illegal = 1'b1;
    endcase
  end

  // A software write to either half replaces the increment for the whole counter.
  always_comb begin
    mcycle_nxt   = mcycle + 64'd1;
    minstret_nxt = minstret + {63'b0, inst_retire};
    if (wr_ok && csr_waddr == A_MCYCLE)    mcycle_nxt   = {mcycle[63:32], csr_wdata};
    if (wr_ok && csr_waddr == A_MCYCLEH)   mcycle_nxt   = {csr_wdata, mcycle[31:0]};
    if (wr_ok && csr_waddr == A_MINSTRET)  minstret_nxt = {minstret[63:32], csr_wdata};
    if (wr_ok && csr_waddr == A_MINSTRETH) minstret_nxt = {csr_wdata, minstret[31:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & LOW2_MASK;
      mscratch <= 32'h0;
      mepc     <= 32'h0;
      mcause   <= 32'h0;
    end else if (trap_en) begin
      mepc   <= trap_pc & LOW2_MASK;
      mcause <= trap_cause;
      mpie   <= mie;
      mie    <= 1'b0;
    end else begin
      if (mret_en) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (wr_ok && csr_waddr == A_MSTATUS) begin
        mie  <= csr_wdata[3];
        mpie <= csr_wdata[7];
      end
      if (wr_ok && csr_waddr == A_MTVEC)    mtvec    <= csr_wdata & LOW2_MASK;
      if (wr_ok && csr_waddr == A_MSCRATCH) mscratch <= csr_wdata;
      if (wr_ok && csr_waddr == A_MEPC)     mepc     <= csr_wdata & LOW2_MASK;
      if (wr_ok && csr_waddr == A_MCAUSE)   mcause   <= csr_wdata;
    end
  end

  assign mtvec_out = mtvec;
  assign mepc_out  = mepc;
  assign mie_out   = mie;

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: directed test-plan sequence, then randomized traffic
// checked every cycle against an architectural model of the CSR state.
module tb_csr_regfile;

  localparam logic [31:0] MTVEC_RESET = 32'h0000_1003;
  localparam logic [31:0] HART_ID     = 32'h0000_0005;

  logic        clk, rst_n;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata, trap_pc, trap_cause, mtvec_out, mepc_out;
  logic        csr_rd_illegal, csr_we, csr_wr_illegal, inst_retire, trap_en, mret_en, mie_out;

  csr_regfile #(.MTVEC_RESET(MTVEC_RESET), .HART_ID(HART_ID)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_rd_illegal(csr_rd_illegal),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wr_illegal(csr_wr_illegal),
    .inst_retire(inst_retire), .trap_en(trap_en), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_en(mret_en), .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_out(mie_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // architectural model
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit writable(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'hB00, 12'hB80, 12'hB02, 12'hB82};
  endfunction

  function automatic bit implemented(input logic [11:0] a);
    return writable(a) || (a inside {12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14});
  endfunction

  function automatic logic [31:0] mread(input logic [11:0] a);
    logic [31:0] st;
    st = 32'h0000_1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
    case (a)
      12'h300: return st;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'hF14: return HART_ID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = MTVEC_RESET & ~32'h3;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  task automatic model_update();
    bit w;
    logic [63:0] nc, ni;
    w  = csr_we && writable(csr_waddr) && !trap_en;
    nc = m_cyc + 64'd1;
    ni = m_ins + (inst_retire ? 64'd1 : 64'd0);
    if (w && csr_waddr == 12'hB00) nc = {m_cyc[63:32], csr_wdata};
    if (w && csr_waddr == 12'hB80) nc = {csr_wdata, m_cyc[31:0]};
    if (w && csr_waddr == 12'hB02) ni = {m_ins[63:32], csr_wdata};
    if (w && csr_waddr == 12'hB82) ni = {csr_wdata, m_ins[31:0]};
    m_cyc = nc;
    m_ins = ni;
    if (trap_en) begin
      m_mepc = trap_pc & ~32'h3;
      m_mcause = trap_cause;
      m_mpie = m_mie;
      m_mie = 0;
    end else begin
      if (mret_en) begin
        m_mie = m_mpie;
        m_mpie = 1;
      end else if (w && csr_waddr == 12'h300) begin
        m_mie = csr_wdata[3];
        m_mpie = csr_wdata[7];
      end
      if (w && csr_waddr == 12'h305) m_mtvec = csr_wdata & ~32'h3;
      if (w && csr_waddr == 12'h340) m_mscratch = csr_wdata;
      if (w && csr_waddr == 12'h341) m_mepc = csr_wdata & ~32'h3;
      if (w && csr_waddr == 12'h342) m_mcause = csr_wdata;
    end
  endtask

  // advance one clock; leaves time 1 unit after the rising edge
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic idle();
    csr_we = 0; trap_en = 0; mret_en = 0; inst_retire = 0;
  endtask

  task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_raddr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata", csr_rdata, mread(csr_raddr));
      check("rd_illegal", {31'b0, csr_rd_illegal}, {31'b0, !implemented(csr_raddr)});
      check("wr_illegal", {31'b0, csr_wr_illegal}, {31'b0, csr_we && !writable(csr_waddr)});
      check("mtvec_out", mtvec_out, m_mtvec);
      check("mepc_out", mepc_out, m_mepc);
      check("mie_out", {31'b0, mie_out}, {31'b0, m_mie});
    end
  end

  logic [11:0] addr_tab [16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                                 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                                 12'hC82, 12'hF14, 12'h301, 12'h7C0};

  initial begin
    rst_n = 0; idle();
    csr_raddr = 12'h300; csr_waddr = 12'h0; csr_wdata = 0; trap_pc = 0; trap_cause = 0;
    #12;
    check("rst_mstatus", csr_rdata, 32'h0000_1800);
    check("rst_mtvec", mtvec_out, 32'h0000_1000);
    check("rst_mepc", mepc_out, 32'h0);
    check("rst_mie", {31'b0, mie_out}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    chk_en = 1;

    rd_check("mcycle0", 12'hB00, 32'd0);
    cycle(); rd_check("mcycle1", 12'hB00, 32'd1);
    cycle(); rd_check("mcycle2", 12'hB00, 32'd2);

    csr_we = 1; csr_waddr = 12'h305; csr_wdata = 32'h8000_0103;
    cycle(); csr_we = 0;
    rd_check("mtvec_wr", 12'h305, 32'h8000_0100);
    check("mtvec_out", mtvec_out, 32'h8000_0100);
    csr_we = 1; csr_waddr = 12'hF14; csr_wdata = 32'h1234_5678;
    #1; check("hartid_wr_illegal", {31'b0, csr_wr_illegal}, 32'h1);
    cycle(); csr_we = 0;
    rd_check("hartid", 12'hF14, HART_ID);

    csr_we = 1; csr_waddr = 12'h300; csr_wdata = 32'h8;
    cycle(); csr_we = 0;
    rd_check("mstatus_mie", 12'h300, 32'h0000_1808);
    trap_en = 1; trap_pc = 32'h0000_0206; trap_cause = 32'h0000_000B;
    cycle(); trap_en = 0;
    rd_check("trap_mepc", 12'h341, 32'h0000_0204);
    rd_check("trap_mcause", 12'h342, 32'h0000_000B);
    rd_check("trap_mstatus", 12'h300, 32'h0000_1880);
    mret_en = 1;
    cycle(); mret_en = 0;
    rd_check("mret_mstatus", 12'h300, 32'h0000_1888);
    check("mret_mie", {31'b0, mie_out}, 32'h1);

    csr_we = 1; csr_waddr = 12'hB00; csr_wdata = 32'hFFFF_FFFF;
    cycle(); csr_waddr = 12'hB80; csr_wdata = 32'h0;
    cycle(); csr_we = 0;
    cycle();
    rd_check("mcycleh_carry", 12'hB80, 32'h1);
    rd_check("mcycle_wrap", 12'hB00, 32'h0);
    csr_we = 1; csr_waddr = 12'hB00; csr_wdata = 32'h5;
    cycle(); csr_we = 0;
    rd_check("mcycle_wr", 12'hB00, 32'h5);

    csr_we = 1; csr_waddr = 12'h340; csr_wdata = 32'hA5A5_A5A5;
    cycle();
    trap_en = 1; csr_wdata = 32'h0; trap_pc = 32'h0000_0100; trap_cause = 32'h7;
    cycle(); trap_en = 0; csr_we = 0;
    rd_check("trap_drops_wr", 12'h340, 32'hA5A5_A5A5);
    csr_we = 1; csr_waddr = 12'h300; csr_wdata = 32'h8;
    cycle(); csr_we = 0;
    trap_en = 1; mret_en = 1; trap_pc = 32'h0000_0333; trap_cause = 32'h3;
    cycle(); trap_en = 0; mret_en = 0;
    rd_check("trap_over_mret", 12'h300, 32'h0000_1880);
    rd_check("trap_over_mret_pc", 12'h341, 32'h0000_0330);

    inst_retire = 1;
    repeat (4) cycle();
    rd_check("instret_pre", 12'hB02, 32'd4);
    rst_n = 0; model_reset();
    #1; check("rst_async_instret", csr_rdata, 32'h0);
    cycle(); cycle();
    rst_n = 1; idle();

    for (int i = 0; i < 3000; i++) begin
      csr_raddr   = ($urandom_range(0, 3) != 0) ? addr_tab[$urandom_range(0, 15)] : 12'($urandom);
      csr_we      = ($urandom_range(0, 2) == 0);
      csr_waddr   = ($urandom_range(0, 7) != 0) ? addr_tab[$urandom_range(0, 15)] : 12'($urandom);
      csr_wdata   = $urandom;
      inst_retire = $urandom_range(0, 1) == 1;
      trap_en     = ($urandom_range(0, 11) == 0);
      mret_en     = ($urandom_range(0, 7) == 0);
      trap_pc     = $urandom;
      trap_cause  = $urandom;
      cycle();
    end
    idle();
    cycle();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
